// File: rtl/wam_round_engine.sv
// ============================================================================
// wam_round_engine
// ----------------------------------------------------------------------------
// Whack-a-mole round engine. Each round lights one pseudo-random hole, times
// it, and judges keypad presses. Score, misses and completed rounds are
// tracked. The game ends on the round limit or according to the game mode:
// DEATHMATCH ends on the first miss, and LIVES ends after MAX_MISSES misses.
//
// Ports
//   clk          in   1        system clock
//   reset        in   1        synchronous, active-high; returns to IDLE
//   start        in   1        1-cycle pulse: begin or restart a game
//   seed_load    in   1        load the LFSR from seed (zero seed -> SEED_DFLT)
//   seed         in   16       LFSR seed
//   mode         in   2        00 NORMAL, 01 DEATHMATCH, 10 LIVES, 11 NORMAL
//   on_ticks     in   CNT_W    lit time   = on_ticks+1 cycles
//   gap_ticks    in   CNT_W    dark time  = gap_ticks+1 cycles
//   total_rounds in   SCORE_W  rounds per game
//   hit          in   N_HOLES  1-cycle press strobes, bit i = hole i
//   lights       out  N_HOLES  hole LEDs (all ones while game over)
//   score        out  SCORE_W  correct hits, saturating
//   misses       out  SCORE_W  timeouts + wrong presses, saturating
//   round_cnt    out  SCORE_W  completed rounds
//   game_over    out  1        high in DONE
//   dbg_state_o  out  2        FSM state (0 IDLE, 1 GAP, 2 LIT, 3 DONE)
//
// Interface contract: there is no valid/ready handshake. start, seed_load and
// hit are single-cycle strobes, and each is acted on at the clock edge where
// it is sampled high. Every output is a register.
// ============================================================================
module wam_round_engine #(
    parameter int          N_HOLES    = 9,
    parameter int          CNT_W      = 28,
    parameter int          SCORE_W    = 6,
    parameter int          MAX_MISSES = 3,
    parameter logic [15:0] SEED_DFLT  = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               seed_load,
    input  logic [15:0]        seed,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   on_ticks,
    input  logic [CNT_W-1:0]   gap_ticks,
    input  logic [SCORE_W-1:0] total_rounds,
    input  logic [N_HOLES-1:0] hit,
    output logic [N_HOLES-1:0] lights,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [SCORE_W-1:0] round_cnt,
    output logic               game_over,
    output logic [1:0]         dbg_state_o
);

    // IW selects the raw index bits from the LFSR. PW is wide enough to also
    // hold N_HOLES, which is the "no previous hole" marker.
    localparam int IW = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
    localparam int PW = $clog2(N_HOLES + 1);

    localparam logic [1:0] MODE_DEATH = 2'b01;
    localparam logic [1:0] MODE_LIVES = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_LIT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [15:0]        lfsr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PW-1:0]      prev_q;
    logic [N_HOLES-1:0] lights_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] misses_q;
    logic [SCORE_W-1:0] round_q;
    logic               game_over_q;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   on_q;
    logic [CNT_W-1:0]   gap_q;
    logic [SCORE_W-1:0] total_q;

    logic [15:0]        lfsr_d;
    logic [PW-1:0]      pick_idx;
    logic [N_HOLES-1:0] pick_onehot;
    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W-1:0] misses_inc;
    logic               hit_ok;
    logic               hit_any;
    logic               round_last;
    logic               lives_out;

    // Right-shifting Galois LFSR, x^16+x^14+x^13+x^11. A seed load takes
    // priority over the step, and a zero seed is replaced by the default so
    // the register can never lock up at zero.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        if (seed_load) begin
            lfsr_d = (seed == 16'h0000) ? SEED_DFLT : seed;
        end
    end

    // Fold the raw index into range, then step past the previous hole so the
    // same hole is never lit twice in a row.
    always_comb begin
        pick_idx = PW'(lfsr_q[IW-1:0]);
        if (pick_idx >= PW'(N_HOLES)) begin
            pick_idx = pick_idx - PW'(N_HOLES);
        end
        if (pick_idx >= PW'(N_HOLES)) begin
            pick_idx = '0;
        end
        if (pick_idx == prev_q) begin
            pick_idx = (pick_idx == PW'(N_HOLES - 1)) ? '0 : pick_idx + PW'(1);
        end
    end

    assign pick_onehot = {{(N_HOLES-1){1'b0}}, 1'b1} << pick_idx;

    // In LIT, lights_q is the one-hot mask of the lit hole, so it doubles as
    // the mask for a correct press.
    assign hit_ok     = |(hit & lights_q);
    assign hit_any    = |hit;
    assign score_inc  = (&score_q)  ? score_q  : score_q  + SCORE_W'(1);
    assign misses_inc = (&misses_q) ? misses_q : misses_q + SCORE_W'(1);
    assign round_last = ({1'b0, round_q} + (SCORE_W+1)'(1)) == {1'b0, total_q};
    assign lives_out  = (misses_inc == SCORE_W'(MAX_MISSES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_DFLT;
            cnt_q       <= '0;
            prev_q      <= PW'(N_HOLES);
            lights_q    <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            round_q     <= '0;
            game_over_q <= 1'b0;
            mode_q      <= 2'b00;
            on_q        <= '0;
            gap_q       <= '0;
            total_q     <= '0;
        end else begin
            lfsr_q <= lfsr_d;

            if (start) begin
                // Restart from any state, including mid-round.
                mode_q   <= mode;
                on_q     <= on_ticks;
                gap_q    <= gap_ticks;
                total_q  <= total_rounds;
                score_q  <= '0;
                misses_q <= '0;
                round_q  <= '0;
                prev_q   <= PW'(N_HOLES);
                cnt_q    <= gap_ticks;
                if (total_rounds == '0) begin
                    state_q     <= S_DONE;
                    game_over_q <= 1'b1;
                    lights_q    <= '1;
                end else begin
                    state_q     <= S_GAP;
                    game_over_q <= 1'b0;
                    lights_q    <= '0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        lights_q <= '0;
                    end

                    S_GAP: begin
                        if (cnt_q == '0) begin
                            state_q  <= S_LIT;
                            cnt_q    <= on_q;
                            prev_q   <= pick_idx;
                            lights_q <= pick_onehot;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end

                    S_LIT: begin
                        // A correct press wins over a simultaneous wrong press
                        // and over the timeout on the same cycle.
                        if (hit_ok || hit_any || (cnt_q == '0)) begin
                            round_q <= round_q + SCORE_W'(1);
                            if (hit_ok) begin
                                score_q <= score_inc;
                            end else begin
                                misses_q <= misses_inc;
                            end
                            if (round_last ||
                                (!hit_ok && (mode_q == MODE_DEATH)) ||
                                (!hit_ok && (mode_q == MODE_LIVES) && lives_out)) begin
                                state_q     <= S_DONE;
                                game_over_q <= 1'b1;
                                lights_q    <= '1;
                            end else begin
                                state_q  <= S_GAP;
                                cnt_q    <= gap_q;
                                lights_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end

                    S_DONE: begin
                        game_over_q <= 1'b1;
                        lights_q    <= '1;
                    end

                    default: begin
                        state_q  <= S_IDLE;
                        lights_q <= '0;
                    end
                endcase
            end
        end
    end

    assign lights      = lights_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign round_cnt   = round_q;
    assign game_over   = game_over_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wam_round_engine.sv
// ============================================================================
// tb_wam_round_engine
// ----------------------------------------------------------------------------
// Directed bench for wam_round_engine. The stimulus process plays rounds and
// pushes the expected {score, misses, round_cnt, game_over} record for every
// round end. A monitor pops one record each time round_cnt steps up and
// compares the record with the outputs. The stimulus process also makes
// direct checks of reset, latency, lit time, restart and the hole sequence.
// ============================================================================
module tb_wam_round_engine;

    localparam int N  = 9;
    localparam int CW = 28;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          seed_load;
    logic [15:0]   seed;
    logic [1:0]    mode;
    logic [CW-1:0] on_ticks;
    logic [CW-1:0] gap_ticks;
    logic [SW-1:0] total_rounds;
    logic [N-1:0]  hit;
    logic [N-1:0]  lights;
    logic [SW-1:0] score;
    logic [SW-1:0] misses;
    logic [SW-1:0] round_cnt;
    logic          game_over;
    logic [1:0]    dbg_state;

    wam_round_engine #(
        .N_HOLES(N), .CNT_W(CW), .SCORE_W(SW), .MAX_MISSES(3), .SEED_DFLT(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .seed(seed),
        .mode(mode), .on_ticks(on_ticks), .gap_ticks(gap_ticks),
        .total_rounds(total_rounds), .hit(hit), .lights(lights), .score(score),
        .misses(misses), .round_cnt(round_cnt), .game_over(game_over),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            total = 0;
    int            bad   = 0;
    bit            sb_en = 1'b0;
    logic [18:0]   exp_q[$];
    logic [SW-1:0] prev_rc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int m, input int r, input int g);
        exp_q.push_back({SW'(s), SW'(m), SW'(r), 1'(g)});
    endtask

    initial begin : monitor
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (sb_en && (round_cnt != prev_rc) && (round_cnt != '0)) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_score",     score,     e[18:13]);
                    check("sb_misses",    misses,    e[12:7]);
                    check("sb_round_cnt", round_cnt, e[6:1]);
                    check("sb_game_over", game_over, e[0]);
                end
            end
            prev_rc = round_cnt;
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic pulse_start(input logic [1:0] md, input int on, input int gap, input int rounds);
        mode         = md;
        on_ticks     = CW'(on);
        gap_ticks    = CW'(gap);
        total_rounds = SW'(rounds);
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_lit(output logic [N-1:0] lit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ($onehot(lights)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lit = lights;
        if (!ok) check("wait_lit_timeout", 32'd0, 32'd1);
    endtask

    // act: 0 no press, 1 correct press 2 cycles after light,
    //      2 wrong press 1 cycle after light, 3 correct+wrong on last lit cycle
    task automatic play_round(input int act, output int lit_cycles);
        logic [N-1:0] lit;
        logic [N-1:0] wrong;
        bit           ok;
        lit_cycles = 0;
        wait_lit(lit, ok);
        wrong = lit[0] ? N'(2) : N'(1);
        if (ok) begin
            case (act)
                0: begin
                    while ($onehot(lights) && lit_cycles < 100) begin
                        lit_cycles++;
                        @(negedge clk);
                    end
                end
                1: begin repeat (2) @(negedge clk); hit = lit;         @(negedge clk); hit = '0; end
                2: begin            @(negedge clk); hit = wrong;       @(negedge clk); hit = '0; end
                default: begin repeat (5) @(negedge clk); hit = lit | wrong; @(negedge clk); hit = '0; end
            endcase
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (game_over) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    // ---------------- main stimulus ----------------
    initial begin : stim
        int           lat;
        int           lc;
        logic [N-1:0] lit;
        bit           ok;
        int           picks;
        int           repeats;
        int           bad_shape;
        logic [N-1:0] prev_lit;

        reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0; mode = '0;
        on_ticks = '0; gap_ticks = '0; total_rounds = '0; hit = '0;
        repeat (3) @(negedge clk);
        check("rst_lights",    lights,    32'd0);
        check("rst_score",     score,     32'd0);
        check("rst_misses",    misses,    32'd0);
        check("rst_round_cnt", round_cnt, 32'd0);
        check("rst_game_over", game_over, 32'd0);
        check("rst_state",     dbg_state, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // presses in IDLE do nothing
        hit = '1; @(negedge clk); hit = '0; @(negedge clk);
        check("idle_hit_misses", misses, 32'd0);
        check("idle_hit_lights", lights, 32'd0);
        sb_en = 1'b1;

        // T1: NORMAL gap=3 on=5 rounds=3, no presses; inputs scrambled after start
        push(0, 1, 1, 0); push(0, 2, 2, 0); push(0, 3, 3, 1);
        pulse_start(2'b00, 5, 3, 3);
        on_ticks = '0; gap_ticks = '0; total_rounds = SW'(1); mode = 2'b01;
        lat = 1;
        while (lights == '0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("t1_first_light_latency", lat, 32'd5);
        for (int r = 0; r < 3; r++) begin
            play_round(0, lc);
            check("t1_lit_cycles", lc, 32'd6);
        end
        wait_done("t1_done");
        check("t1_done_lights", lights, 32'h1FF);

        // T2: NORMAL, correct press every round
        push(1, 0, 1, 0); push(2, 0, 2, 0); push(3, 0, 3, 1);
        pulse_start(2'b00, 5, 3, 3);
        for (int r = 0; r < 3; r++) play_round(1, lc);
        wait_done("t2_done");

        // T3: DEATHMATCH rounds=10, wrong press in round 2 ends the game
        push(1, 0, 1, 0); push(1, 1, 2, 1);
        pulse_start(2'b01, 5, 3, 10);
        play_round(1, lc);
        play_round(2, lc);
        wait_done("t3_done");
        check("t3_state_done", dbg_state, 32'd3);

        // T4: LIVES rounds=20, no presses -> over after exactly 3 rounds
        push(0, 1, 1, 0); push(0, 2, 2, 0); push(0, 3, 3, 1);
        pulse_start(2'b10, 5, 3, 20);
        for (int r = 0; r < 3; r++) play_round(0, lc);
        wait_done("t4_done");
        repeat (5) @(negedge clk);
        check("t4_round_cnt_held", round_cnt, 32'd3);

        // T5: correct + wrong press on the timeout cycle counts as a hit
        push(1, 0, 1, 0); push(1, 1, 2, 1);
        pulse_start(2'b00, 5, 3, 2);
        play_round(3, lc);
        play_round(0, lc);
        wait_done("t5_done");
        hit = '1; @(negedge clk); hit = '0; @(negedge clk);
        check("t5_done_hit_score",  score,  32'd1);
        check("t5_done_hit_misses", misses, 32'd1);

        // T6: restart mid-LIT, press in GAP, reset mid-GAP
        push(0, 1, 1, 0);
        pulse_start(2'b00, 5, 3, 3);
        play_round(0, lc);
        wait_lit(lit, ok);
        pulse_start(2'b00, 5, 3, 3);
        check("t6_restart_score",  score,     32'd0);
        check("t6_restart_misses", misses,    32'd0);
        check("t6_restart_rounds", round_cnt, 32'd0);
        check("t6_restart_lights", lights,    32'd0);
        hit = '1; @(negedge clk); hit = '0;
        check("t6_gap_hit_misses", misses, 32'd0);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        check("t6_reset_lights", lights,    32'd0);
        check("t6_reset_state",  dbg_state, 32'd0);
        repeat (10) @(negedge clk);
        check("t6_idle_dark", lights, 32'd0);

        // start with zero rounds goes straight to game over
        pulse_start(2'b00, 5, 3, 0);
        check("t6_zero_rounds_over",   game_over, 32'd1);
        check("t6_zero_rounds_lights", lights,    32'h1FF);
        check("t6_zero_rounds_cnt",    round_cnt, 32'd0);

        // T7: zero seed load, then 2000 picks (40 games x 50 rounds)
        sb_en = 1'b0;
        seed_load = 1'b1; seed = 16'h0000; @(negedge clk); seed_load = 1'b0;
        picks = 0; repeats = 0; bad_shape = 0;
        for (int g = 0; g < 40; g++) begin
            pulse_start(2'b00, 0, 0, 50);
            prev_lit = '0;
            for (int c = 0; c < 300 && !game_over; c++) begin
                if (lights != '0) begin
                    picks++;
                    if (!$onehot(lights)) bad_shape++;
                    if (lights == prev_lit) repeats++;
                    prev_lit = lights;
                end
                @(negedge clk);
            end
        end
        check("t7_pick_count",   picks,     32'd2000);
        check("t7_repeat_holes", repeats,   32'd0);
        check("t7_bad_onehot",   bad_shape, 32'd0);

        check("sb_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
